// File: rtl/pe_column_drain.sv
`default_nettype none
// ============================================================================
// Module      : pe_column_drain
// Description : Output collector at the bottom of a PE column's vertical
//               result chain. Shifts NUM_ROWS results out one per cycle,
//               converts each to the layer precision (8/4/2 bit, saturate or
//               truncate), packs them LSB-first into 32-bit words and emits
//               the words on a valid/ready stream.
// Ports       : clk, reset (async, active-high)
//               start, PRECISION, sat_en      - drain control (sampled on start)
//               col_in / drain_shift          - column value and shift enable
//               out_data/out_valid/out_ready/out_last - packed word stream
//               busy, done                    - drain status
// Revision    : 1.0 - initial release
// ============================================================================
module pe_column_drain #(
    parameter int ACC_DATA_WIDTH = 32,
    parameter int NUM_ROWS       = 16,
    parameter int OUT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [1:0]                PRECISION,
    input  logic                      sat_en,
    input  logic [ACC_DATA_WIDTH-1:0] col_in,
    output logic                      drain_shift,
    output logic [OUT_WIDTH-1:0]      out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done
);

    localparam int c_rw = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam logic [c_rw-1:0] c_last_row = c_rw'(NUM_ROWS - 1);

    localparam logic signed [ACC_DATA_WIDTH-1:0] c_max8 = 127;
    localparam logic signed [ACC_DATA_WIDTH-1:0] c_min8 = -128;
    localparam logic signed [ACC_DATA_WIDTH-1:0] c_max4 = 7;
    localparam logic signed [ACC_DATA_WIDTH-1:0] c_min4 = -8;
    localparam logic signed [ACC_DATA_WIDTH-1:0] c_max2 = 1;
    localparam logic signed [ACC_DATA_WIDTH-1:0] c_min2 = -2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_EMIT  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             prec_q, prec_d;
    logic                   sat_q, sat_d;
    logic [c_rw-1:0]        row_cnt_q, row_cnt_d;
    logic [3:0]             lane_cnt_q, lane_cnt_d;
    logic [OUT_WIDTH-1:0]   pack_q, pack_d;
    logic [OUT_WIDTH-1:0]   out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_last_q, out_last_d;
    logic                   drain_shift_q, drain_shift_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic signed [ACC_DATA_WIDTH-1:0] col_s;
    logic [7:0]             lane_val;
    logic [4:0]             lane_shift;
    logic [3:0]             lanes_m1;
    logic [OUT_WIDTH-1:0]   pack_next;
    logic                   row_last;

    assign col_s = signed'(col_in);

    // Lane conversion, bit offset of the current lane, and lanes per word - 1,
    // all driven by the precision captured at start. Code 3 behaves as 8-bit.
    always_comb begin
        lane_val   = '0;
        lane_shift = '0;
        lanes_m1   = 4'd3;
        case (prec_q)
            2'd1: begin
                lanes_m1   = 4'd7;
                lane_shift = {lane_cnt_q[2:0], 2'b00};
                if (sat_q && (col_s > c_max4))      lane_val = 8'h07;
                else if (sat_q && (col_s < c_min4)) lane_val = 8'h08;
                else                                lane_val = {4'b0000, col_in[3:0]};
            end
            2'd2: begin
                lanes_m1   = 4'd15;
                lane_shift = {lane_cnt_q, 1'b0};
                if (sat_q && (col_s > c_max2))      lane_val = 8'h01;
                else if (sat_q && (col_s < c_min2)) lane_val = 8'h02;
                else                                lane_val = {6'b000000, col_in[1:0]};
            end
            default: begin
                lanes_m1   = 4'd3;
                lane_shift = {lane_cnt_q[1:0], 3'b000};
                if (sat_q && (col_s > c_max8))      lane_val = 8'h7F;
                else if (sat_q && (col_s < c_min8)) lane_val = 8'h80;
                else                                lane_val = col_in[7:0];
            end
        endcase
    end

    // The pack register is cleared before each word, so OR-ing in the new lane
    // is enough; unused lanes of a short final word stay zero.
    assign pack_next = pack_q | (OUT_WIDTH'(lane_val) << lane_shift);
    assign row_last  = (row_cnt_q == c_last_row);

    always_comb begin
        state_d       = state_q;
        prec_d        = prec_q;
        sat_d         = sat_q;
        row_cnt_d     = row_cnt_q;
        lane_cnt_d    = lane_cnt_q;
        pack_d        = pack_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        out_last_d    = out_last_q;
        drain_shift_d = drain_shift_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                drain_shift_d = 1'b0;
                if (start) begin
                    state_d       = ST_DRAIN;
                    prec_d        = PRECISION;
                    sat_d         = sat_en;
                    row_cnt_d     = '0;
                    lane_cnt_d    = '0;
                    pack_d        = '0;
                    drain_shift_d = 1'b1;
                    busy_d        = 1'b1;
                end
            end
            ST_DRAIN: begin
                pack_d     = pack_next;
                row_cnt_d  = row_cnt_q + c_rw'(1);
                lane_cnt_d = lane_cnt_q + 4'd1;
                if ((lane_cnt_q == lanes_m1) || row_last) begin
                    out_data_d    = pack_next;
                    out_valid_d   = 1'b1;
                    out_last_d    = row_last;
                    drain_shift_d = 1'b0;
                    state_d       = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    lane_cnt_d  = '0;
                    pack_d      = '0;
                    if (out_last_q) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        drain_shift_d = 1'b1;
                        state_d       = ST_DRAIN;
                    end
                end
            end
            default: begin
                state_d       = ST_IDLE;
                drain_shift_d = 1'b0;
                busy_d        = 1'b0;
                out_valid_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            prec_q        <= '0;
            sat_q         <= 1'b0;
            row_cnt_q     <= '0;
            lane_cnt_q    <= '0;
            pack_q        <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            drain_shift_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            prec_q        <= prec_d;
            sat_q         <= sat_d;
            row_cnt_q     <= row_cnt_d;
            lane_cnt_q    <= lane_cnt_d;
            pack_q        <= pack_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            drain_shift_q <= drain_shift_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign drain_shift = drain_shift_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_column_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_column_drain
// Description : Self-checking bench for pe_column_drain. Table vectors with
//               fixed expected words, hand-written corner sequences (reset
//               mid-drain, 5-row partial word) and randomized drains checked
//               against a lane-packing reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_column_drain;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  PRECISION;
    logic        sat_en;
    logic [31:0] col_in;
    logic        drain_shift;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;

    // second instance with a short column to exercise the partial word
    logic        start5;
    logic [31:0] col_in5;
    logic        drain_shift5;
    logic [31:0] out_data5;
    logic        out_valid5;
    logic        out_last5;
    logic        busy5;
    logic        done5;

    always #5 clk = ~clk;

    pe_column_drain #(.ACC_DATA_WIDTH(32), .NUM_ROWS(16), .OUT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .PRECISION(PRECISION),
        .sat_en(sat_en), .col_in(col_in), .drain_shift(drain_shift),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done)
    );

    pe_column_drain #(.ACC_DATA_WIDTH(32), .NUM_ROWS(5), .OUT_WIDTH(32)) dut5 (
        .clk(clk), .reset(reset), .start(start5), .PRECISION(2'd2),
        .sat_en(1'b1), .col_in(col_in5), .drain_shift(drain_shift5),
        .out_data(out_data5), .out_valid(out_valid5), .out_ready(1'b1),
        .out_last(out_last5), .busy(busy5), .done(done5)
    );

    // ---------------- column emulation ----------------
    int   col_vals [16];
    int   col_idx;
    logic col_load;
    int   col5_vals [5];
    int   col5_idx;

    always @(posedge clk) begin
        if (col_load) col_idx <= 0;
        else if (drain_shift && col_idx < 16) col_idx <= col_idx + 1;
        if (start5) col5_idx <= 0;
        else if (drain_shift5 && col5_idx < 5) col5_idx <= col5_idx + 1;
    end

    always_comb begin
        col_in  = (col_idx < 16) ? col_vals[col_idx] : 32'd0;
        col_in5 = (col5_idx < 5) ? col5_vals[col5_idx] : 32'd0;
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: word wi of a drain, built from lane rules directly.
    function automatic logic [31:0] model_word(input logic [1:0] p, input bit s,
                                               input int nrows, input int wi,
                                               input int v [16]);
        int          w;
        int          l;
        longint      x;
        longint      lo;
        longint      hi;
        logic [31:0] word;
        w    = (p == 2'd1) ? 4 : (p == 2'd2) ? 2 : 8;
        l    = 32 / w;
        word = '0;
        for (int k = 0; k < l; k++) begin
            int r;
            r = wi * l + k;
            if (r < nrows) begin
                x  = longint'(v[r]);
                lo = -(longint'(1) << (w - 1));
                hi = (longint'(1) << (w - 1)) - 1;
                if (s) begin
                    if (x > hi) x = hi;
                    if (x < lo) x = lo;
                end
                x    = x & ((longint'(1) << w) - 1);
                word = word | (32'(x) << (k * w));
            end
        end
        return word;
    endfunction

    // ---------------- drain driver ----------------
    logic [31:0] got_words [4];
    bit          got_last  [4];
    int          got_n;
    int          got_done;

    // Runs one drain. done cycle counts edges after the edge that took start.
    task automatic run_drain(input logic [1:0] p, input bit s, input int stall_word,
                             input int stall_n, input bit rnd_ready, input bit poke);
        int          cyc;
        int          stall_left;
        bit          prev_hold;
        logic [31:0] prev_data;
        @(negedge clk);
        PRECISION = p;
        sat_en    = s;
        start     = 1'b1;
        col_load  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        col_load = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("shift_after_start", {31'd0, drain_shift}, 32'd1);
        got_n      = 0;
        got_done   = -1;
        stall_left = stall_n;
        prev_hold  = 1'b0;
        prev_data  = '0;
        cyc        = 0;
        while (cyc < 400) begin
            if (done) begin
                got_done = cyc;
                check("busy_at_done", {31'd0, busy}, 32'd0);
                break;
            end
            if (prev_hold) begin
                check("valid_held", {31'd0, out_valid}, 32'd1);
                check("data_held", out_data, prev_data);
            end
            if (poke && cyc == 2) begin
                start     = 1'b1;
                PRECISION = p ^ 2'b01;
                sat_en    = ~s;
                col_load  = 1'b0;
            end else begin
                start = 1'b0;
            end
            if (out_valid) begin
                check("no_shift_in_emit", {31'd0, drain_shift}, 32'd0);
                if (got_n == stall_word && stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                end else if (rnd_ready) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                end else begin
                    out_ready = 1'b1;
                end
                if (out_ready) begin
                    if (got_n < 4) begin
                        got_words[got_n] = out_data;
                        got_last[got_n]  = out_last;
                    end
                    got_n++;
                end
                prev_hold = !out_ready;
                prev_data = out_data;
            end else begin
                out_ready = rnd_ready ? ($urandom_range(0, 1) != 0) : 1'b1;
                prev_hold = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        if (got_done < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got no done expected done within 400 cycles");
        end
    endtask

    task automatic load_pattern(input int pat);
        for (int i = 0; i < 16; i++)
            col_vals[i] = (pat == 0) ? (i + 1) : ((i % 2 == 0) ? 100 : -100);
    endtask

    typedef struct {
        logic [1:0]  prec;
        bit          sat;
        int          pat;
        int          stall;
        bit          poke;
        int          nw;
        int          exp_done;
        logic [31:0] w [4];
    } vec_t;

    vec_t vecs [6];

    initial begin
        // 8-bit truncate, 1..16
        vecs[0] = '{2'd0, 1'b0, 0, 0, 1'b0, 4, 20,
                    '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D}};
        // 4-bit saturate, +100/-100 -> 7,8 per lane pair
        vecs[1] = '{2'd1, 1'b1, 1, 0, 1'b0, 2, 18,
                    '{32'h87878787, 32'h87878787, 32'h0, 32'h0}};
        // backpressure: 10 stalled cycles on the second word
        vecs[2] = '{2'd0, 1'b0, 0, 10, 1'b0, 4, 30,
                    '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D}};
        // code 3 behaves as 8-bit
        vecs[3] = '{2'd3, 1'b0, 0, 0, 1'b0, 4, 20,
                    '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D}};
        // 2-bit truncate of 1..16: lanes 1,2,3,0 repeating -> 0x39 per byte
        vecs[4] = '{2'd2, 1'b0, 0, 0, 1'b0, 1, 17,
                    '{32'h39393939, 32'h0, 32'h0, 32'h0}};
        // start pulse and PRECISION/sat_en changes mid-drain are ignored
        vecs[5] = '{2'd0, 1'b0, 0, 0, 1'b1, 4, 20,
                    '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D}};

        reset     = 1'b1;
        start     = 1'b0;
        start5    = 1'b0;
        col_load  = 1'b1;
        PRECISION = 2'd0;
        sat_en    = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) col_vals[i] = 0;
        col5_vals = '{1, -1, 5, -5, 0};
        repeat (3) @(negedge clk);
        check("rst_out_data", out_data, 32'd0);
        check("rst_flags", {26'd0, out_valid, out_last, drain_shift, busy, done, 1'b0}, 32'd0);
        reset    = 1'b0;
        col_load = 1'b0;
        @(negedge clk);

        // ---------------- table vectors ----------------
        foreach (vecs[vi]) begin
            load_pattern(vecs[vi].pat);
            run_drain(vecs[vi].prec, vecs[vi].sat, 1, vecs[vi].stall, 1'b0, vecs[vi].poke);
            check($sformatf("v%0d_nwords", vi), got_n, vecs[vi].nw);
            check($sformatf("v%0d_done_cyc", vi), got_done, vecs[vi].exp_done);
            for (int k = 0; k < vecs[vi].nw && k < got_n && k < 4; k++) begin
                check($sformatf("v%0d_word%0d", vi, k), got_words[k], vecs[vi].w[k]);
                check($sformatf("v%0d_last%0d", vi, k), {31'd0, got_last[k]},
                      {31'd0, (k == vecs[vi].nw - 1)});
            end
        end

        // ---------------- reset during the third DRAIN cycle ----------------
        load_pattern(0);
        @(negedge clk);
        PRECISION = 2'd0;
        sat_en    = 1'b0;
        start     = 1'b1;
        col_load  = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        col_load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_data", out_data, 32'd0);
        check("rst_mid_flags", {27'd0, out_valid, out_last, drain_shift, busy, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done || out_valid || busy) begin
                check("rst_no_activity", {29'd0, done, out_valid, busy}, 32'd0);
                break;
            end
        end
        run_drain(2'd0, 1'b0, 0, 0, 1'b0, 1'b0);
        check("post_rst_nwords", got_n, 4);
        check("post_rst_done", got_done, 20);
        for (int k = 0; k < 4 && k < got_n; k++)
            check($sformatf("post_rst_word%0d", k), got_words[k], vecs[0].w[k]);

        // ---------------- 5-row column, 2-bit saturate ----------------
        // 1->01, -1->11, 5->01, -5->10, 0->00  gives 0b10_01_11_01 = 0x9D
        begin
            int          n5;
            int          d5;
            logic [31:0] w5;
            bit          l5;
            n5 = 0; d5 = -1; w5 = '0; l5 = 1'b0;
            @(negedge clk);
            start5 = 1'b1;
            @(negedge clk);
            start5 = 1'b0;
            for (int c = 0; c < 60; c++) begin
                if (done5) begin d5 = c; break; end
                if (out_valid5) begin w5 = out_data5; l5 = out_last5; n5++; end
                @(negedge clk);
            end
            check("r5_nwords", n5, 1);
            check("r5_word", w5, 32'h0000009D);
            check("r5_last", {31'd0, l5}, 32'd1);
            check("r5_done_cyc", d5, 6);
        end

        // ---------------- randomized drains vs reference model ----------------
        for (int t = 0; t < 24; t++) begin
            logic [1:0] p;
            bit         s;
            int         mode;
            int         nexp;
            p    = 2'($urandom_range(0, 3));
            s    = 1'($urandom_range(0, 1));
            mode = $urandom_range(0, 2);
            for (int i = 0; i < 16; i++) begin
                if (mode == 0)      col_vals[i] = int'($urandom);
                else if (mode == 1) col_vals[i] = $urandom_range(0, 40) - 20;
                else                col_vals[i] = $urandom_range(0, 600) - 300;
            end
            nexp = (p == 2'd1) ? 2 : (p == 2'd2) ? 1 : 4;
            run_drain(p, s, -1, 0, 1'b1, 1'($urandom_range(0, 1)));
            check($sformatf("rnd%0d_nwords", t), got_n, nexp);
            for (int k = 0; k < nexp && k < got_n && k < 4; k++) begin
                check($sformatf("rnd%0d_word%0d", t, k), got_words[k],
                      model_word(p, s, 16, k, col_vals));
                check($sformatf("rnd%0d_last%0d", t, k), {31'd0, got_last[k]},
                      {31'd0, (k == nexp - 1)});
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
